// File: rtl/acc_multicycle_core.sv
// Multicycle accumulator core: four accumulators, C/Z/N flags, and one memory
// port with a req/ack handshake that tolerates any number of wait cycles.
module acc_multicycle_core #(
    parameter int DATA_W   = 8,
    parameter int RESET_PC = 0,
    localparam int ADDR_W  = 2*DATA_W-3
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    input  logic [1:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_acc,
    output logic [2:0]        czn,
    output logic              halted
);

    // Handshake: mem_req/mem_we/mem_addr/mem_wdata are held stable from the
    // cycle mem_req rises until the rising edge that samples mem_ack=1.
    typedef enum logic [2:0] {FETCH, FETCH2, MEMRD, MEMWR, EXEC, WB, HALT} state_t;

    state_t            state, next_state;
    logic [ADDR_W-1:0] pc, pc_inc, jaddr, maddr;
    logic [DATA_W-1:0] ir, tr, res;
    logic [DATA_W-1:0] acc [4];
    logic              c, z, n;
    logic [2:0]        op, rdata_op;
    logic [1:0]        rd, rs;
    logic [DATA_W-1:0] a_val, b_val, alu_res;
    logic [DATA_W:0]   sum;
    logic              alu_c, in_mem, take_jump;

    assign op        = ir[DATA_W-1 -: 3];
    assign rdata_op  = mem_rdata[DATA_W-1 -: 3];
    assign rd        = ir[3:2];
    assign rs        = ir[1:0];
    assign pc_inc    = pc + ADDR_W'(1);
    assign jaddr     = {ir[DATA_W-4:0], mem_rdata};
    assign maddr     = {ir[DATA_W-4:0], tr};
    assign a_val     = acc[rd];
    assign b_val     = acc[rs];
    assign sum       = {1'b0, a_val} + {1'b0, b_val};
    assign take_jump = (op == 3'b010) || ((op == 3'b011) && z);

    // MOV falls through to the default: result is A[rs], carry untouched.
    always_comb begin
        alu_res = b_val;
        alu_c   = c;
        case (op)
            3'b100: begin
                alu_res = sum[DATA_W-1:0];
                alu_c   = sum[DATA_W];
            end
            3'b101: begin
                alu_res = a_val - b_val;
                alu_c   = (a_val >= b_val);
            end
            3'b110: alu_res = a_val & b_val;
            default: ;
        endcase
    end

    always_comb begin
        next_state = state;
        in_mem     = 1'b0;
        case (state)
            FETCH: begin
                in_mem = 1'b1;
                if (mem_ack) begin
                    if (rdata_op <= 3'b011)
                        next_state = FETCH2;
                    else if (rdata_op == 3'b111 && mem_rdata[DATA_W-4])
                        next_state = HALT;
                    else
                        next_state = EXEC;
                end
            end
            FETCH2: begin
                in_mem = 1'b1;
                if (mem_ack) begin
                    if (op == 3'b000)      next_state = MEMRD;
                    else if (op == 3'b001) next_state = MEMWR;
                    else                   next_state = FETCH;
                end
            end
            MEMRD, MEMWR: begin
                in_mem = 1'b1;
                if (mem_ack) next_state = FETCH;
            end
            EXEC:    next_state = WB;
            WB:      next_state = FETCH;
            HALT:    next_state = HALT;
            default: next_state = FETCH;
        endcase
    end

    // Gating with rst lets a reset abandon an outstanding request at once.
    assign mem_req   = in_mem & ~rst;
    assign mem_we    = mem_req & (state == MEMWR);
    assign mem_addr  = (state == MEMRD || state == MEMWR) ? maddr : pc;
    assign mem_wdata = acc[0];
    assign dbg_acc   = acc[dbg_sel];
    assign czn       = {c, z, n};
    assign halted    = (state == HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= next_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc  <= ADDR_W'(RESET_PC);
            ir  <= '0;
            tr  <= '0;
            res <= '0;
            for (int i = 0; i < 4; i++) acc[i] <= '0;
            c   <= 1'b0;
            z   <= 1'b0;
            n   <= 1'b0;
        end else begin
            case (state)
                FETCH: if (mem_ack) begin
                    ir <= mem_rdata;
                    pc <= pc_inc;
                end
                FETCH2: if (mem_ack) begin
                    tr <= mem_rdata;
                    pc <= take_jump ? jaddr : pc_inc;
                end
                MEMRD: if (mem_ack) acc[0] <= mem_rdata;
                EXEC: begin
                    res <= alu_res;
                    if (op != 3'b111) begin
                        c <= alu_c;
                        z <= (alu_res == '0);
                        n <= alu_res[DATA_W-1];
                    end
                end
                WB: acc[rd] <= res;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_multicycle_core.sv
// Bench for acc_multicycle_core: a memory responder with random wait states, an
// instruction-level reference model feeding a transaction scoreboard.
module tb_acc_multicycle_core;

    logic        clk, rst;
    logic        mem_req, mem_we, mem_ack;
    logic [12:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata, dbg_acc;
    logic [1:0]  dbg_sel;
    logic [2:0]  czn;
    logic        halted;

    logic        mem_req2, mem_we2, mem_ack2, halted2;
    logic [12:0] mem_addr2;
    logic [7:0]  mem_wdata2, mem_rdata2, dbg_acc2;
    logic [1:0]  dbg_sel2;
    logic [2:0]  czn2;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [21:0] exp_q[$];
    logic [12:0] addr2_q[$];
    logic [7:0]  mem [8192];
    logic [7:0]  mm  [8192];
    logic [7:0]  ma  [4];
    logic        mc, mz, mn;
    int          m_cycles;
    int          fixed_wait, max_wait, total_waits, txn_cnt;
    bit          sb_en;

    acc_multicycle_core #(.DATA_W(8), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .dbg_sel(dbg_sel), .dbg_acc(dbg_acc),
        .czn(czn), .halted(halted)
    );

    acc_multicycle_core #(.DATA_W(8), .RESET_PC(13'h1FFF)) dut2 (
        .clk(clk), .rst(rst), .mem_req(mem_req2), .mem_we(mem_we2),
        .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2),
        .mem_ack(mem_ack2), .dbg_sel(dbg_sel2), .dbg_acc(dbg_acc2),
        .czn(czn2), .halted(halted2)
    );

    // Second core: MOV at the top of memory, HALT everywhere else, zero wait.
    assign mem_rdata2 = (mem_addr2 == 13'h1FFF) ? 8'hE4 : 8'hF0;
    assign mem_ack2   = mem_req2;
    assign dbg_sel2   = 2'd1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Memory responder and scoreboard monitor.
    initial begin : responder
        logic        active;
        logic [12:0] cap_addr;
        logic        cap_we;
        logic [7:0]  cap_wd;
        logic [21:0] e;
        int          rem, cap_w;
        bit          unstable;
        mem_ack = 1'b0;
        mem_rdata = 8'h00;
        active = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mem_ack = 1'b0;
                active = 1'b0;
            end else begin
                if (mem_ack) begin
                    mem_ack = 1'b0;
                    active = 1'b0;
                end
                if (mem_req && !active) begin
                    active = 1'b1;
                    cap_addr = mem_addr;
                    cap_we = mem_we;
                    cap_wd = mem_wdata;
                    cap_w = (fixed_wait >= 0) ? fixed_wait : $urandom_range(0, max_wait);
                    rem = cap_w;
                    unstable = 1'b0;
                end
                if (active) begin
                    if (mem_req !== 1'b1 || mem_addr !== cap_addr || mem_we !== cap_we ||
                        (cap_we && mem_wdata !== cap_wd))
                        unstable = 1'b1;
                    if (rem == 0) begin
                        if (cap_w > 0) chk("txn_stable", {31'd0, unstable}, 32'd0);
                        mem_rdata = mem[cap_addr];
                        if (cap_we) mem[cap_addr] = cap_wd;
                        mem_ack = 1'b1;
                        txn_cnt++;
                        if (sb_en) begin
                            if (exp_q.size() == 0) begin
                                chk("txn_unexpected", {9'd0, cap_we, cap_addr, cap_wd}, 32'd0);
                            end else begin
                                e = exp_q.pop_front();
                                chk("txn", {10'd0, cap_we, cap_addr, cap_we ? cap_wd : 8'h00}, {10'd0, e});
                            end
                        end
                    end else begin
                        rem--;
                        total_waits++;
                    end
                end
            end
        end
    end

    initial begin : mon2
        forever begin
            @(negedge clk);
            if (rst) addr2_q.delete();
            else if (mem_req2 && addr2_q.size() < 4) addr2_q.push_back(mem_addr2);
        end
    end

    // Instruction-level model: walks the program in mm, queues the memory
    // transactions it implies and totals the zero-wait cycle count.
    task automatic run_model();
        logic [12:0] pc, ad;
        logic [7:0]  ir, lo, a, b, r;
        logic [2:0]  op;
        int          rd, rs, s;
        bit          done;
        pc = 13'd0;
        for (int i = 0; i < 4; i++) ma[i] = 8'h00;
        mc = 1'b0; mz = 1'b0; mn = 1'b0;
        m_cycles = 0;
        done = 1'b0;
        for (int step = 0; step < 2000 && !done; step++) begin
            exp_q.push_back({1'b0, pc, 8'h00});
            ir = mm[pc];
            pc = pc + 13'd1;
            op = ir[7:5];
            if (op <= 3'd3) begin
                exp_q.push_back({1'b0, pc, 8'h00});
                lo = mm[pc];
                pc = pc + 13'd1;
                ad = {ir[4:0], lo};
                case (op)
                    3'd0: begin exp_q.push_back({1'b0, ad, 8'h00}); ma[0] = mm[ad]; m_cycles += 3; end
                    3'd1: begin exp_q.push_back({1'b1, ad, ma[0]}); mm[ad] = ma[0]; m_cycles += 3; end
                    3'd2: begin pc = ad; m_cycles += 2; end
                    default: begin if (mz) pc = ad; m_cycles += 2; end
                endcase
            end else if (op == 3'd7 && ir[4]) begin
                done = 1'b1;
                m_cycles += 1;
            end else begin
                rd = int'(ir[3:2]);
                rs = int'(ir[1:0]);
                a = ma[rd];
                b = ma[rs];
                m_cycles += 3;
                case (op)
                    3'd4: begin s = int'(a) + int'(b); mc = (s > 255); r = 8'(s); end
                    3'd5: begin mc = (a >= b); r = a - b; end
                    3'd6: r = a & b;
                    default: r = b;
                endcase
                if (op != 3'd7) begin
                    mz = (r == 8'h00);
                    mn = r[7];
                end
                ma[rd] = r;
            end
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 8192; i++) mem[i] = 8'hF0;
        for (int i = 16'h1000; i < 16'h1010; i++) mem[i] = 8'($urandom);
    endtask

    task automatic gen_random();
        int          n, r;
        logic [2:0]  ops [16];
        logic [12:0] at [17];
        logic [12:0] ad;
        n = $urandom_range(4, 14);
        at[0] = 13'd0;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 9);
            ops[i] = (r == 9) ? 3'd4 : (r == 8) ? 3'd0 : 3'(r);
            at[i+1] = at[i] + ((ops[i] <= 3'd3) ? 13'd2 : 13'd1);
        end
        for (int i = 0; i < n; i++) begin
            if (ops[i] <= 3'd1) begin
                mem[at[i]] = {ops[i], 5'b10000};
                mem[at[i]+13'd1] = 8'($urandom_range(0, 15));
            end else if (ops[i] <= 3'd3) begin
                ad = at[$urandom_range(i+1, n)];
                mem[at[i]] = {ops[i], ad[12:8]};
                mem[at[i]+13'd1] = ad[7:0];
            end else begin
                mem[at[i]] = {ops[i], (ops[i] == 3'd7) ? 1'b0 : 1'($urandom), 4'($urandom)};
            end
        end
        mem[at[n]] = 8'hF0;
    endtask

    task automatic check_reset_state();
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_czn", {29'd0, czn}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            chk("rst_acc", {24'd0, dbg_acc}, 32'd0);
        end
    endtask

    task automatic run_test(input int fw, input int mw);
        int cyc, bad;
        fixed_wait = fw;
        max_wait = mw;
        rst = 1'b1;
        sb_en = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 8192; i++) mm[i] = mem[i];
        run_model();
        repeat (2) @(posedge clk);
        #1;
        check_reset_state();
        txn_cnt = 0;
        total_waits = 0;
        @(posedge clk);
        #2 rst = 1'b0;
        cyc = 0;
        while (1) begin
            @(posedge clk);
            cyc++;
            #1;
            if (halted) break;
            if (cyc > 5000) begin
                chk("halt_timeout", 32'(cyc), 32'd0);
                break;
            end
        end
        chk("cycles", 32'(cyc), 32'(m_cycles + total_waits));
        repeat (2) @(posedge clk);
        #1;
        chk("halted", {31'd0, halted}, 32'd1);
        chk("halt_no_req", {31'd0, mem_req}, 32'd0);
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        chk("czn", {29'd0, czn}, {29'd0, mc, mz, mn});
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            chk("acc", {24'd0, dbg_acc}, {24'd0, ma[i]});
        end
        bad = 0;
        for (int i = 0; i < 8192; i++) if (mem[i] !== mm[i]) bad++;
        chk("mem_image", 32'(bad), 32'd0);
    endtask

    task automatic load_037();
        clear_mem();
        mem[0] = 8'h01; mem[1] = 8'h00; mem[2] = 8'h80;
        mem[3] = 8'h21; mem[4] = 8'h01; mem[5] = 8'hF0;
        mem[13'h100] = 8'h05;
    endtask

    task automatic check_037();
        dbg_sel = 2'd0;
        #1;
        chk("p037_a0", {24'd0, dbg_acc}, 32'h0A);
        chk("p037_m101", {24'd0, mem[13'h101]}, 32'h0A);
        chk("p037_czn", {29'd0, czn}, 32'd0);
        chk("p037_txns", 32'(txn_cnt), 32'd8);
    endtask

    initial begin : stim
        int cyc;
        rst = 1'b1;
        dbg_sel = 2'd0;
        sb_en = 1'b0;
        fixed_wait = 0;
        max_wait = 0;
        txn_cnt = 0;
        total_waits = 0;

        load_037();
        run_test(0, 0);
        check_037();
        chk("wrap_n", 32'(addr2_q.size()), 32'd2);
        if (addr2_q.size() >= 2) begin
            chk("wrap_first", {19'd0, addr2_q[0]}, 32'h1FFF);
            chk("wrap_next", {19'd0, addr2_q[1]}, 32'h0000);
        end
        chk("wrap_halted", {31'd0, halted2}, 32'd1);

        load_037();
        run_test(3, 0);
        check_037();

        clear_mem();
        mem[0] = 8'h10; mem[1] = 8'h00; mem[2] = 8'hA0;
        mem[3] = 8'h60; mem[4] = 8'h10; mem[5] = 8'h80;
        mem[13'h1000] = 8'h33;
        run_test(0, 0);
        dbg_sel = 2'd0;
        #1;
        chk("p038_a0", {24'd0, dbg_acc}, 32'd0);
        chk("p038_czn", {29'd0, czn}, 32'b110);

        clear_mem();
        mem[0] = 8'h10; mem[1] = 8'h00; mem[2] = 8'h80; mem[3] = 8'hE4; mem[4] = 8'hF0;
        mem[13'h1000] = 8'hFF;
        run_test(0, 0);
        dbg_sel = 2'd1;
        #1;
        chk("p039_a1", {24'd0, dbg_acc}, 32'hFE);
        chk("p039_czn", {29'd0, czn}, 32'b101);

        for (int t = 0; t < 20; t++) begin
            clear_mem();
            gen_random();
            run_test(-1, 3);
        end

        // Reset while a store is waiting for its ack.
        clear_mem();
        mem[0] = 8'h10; mem[1] = 8'h00; mem[2] = 8'h32; mem[3] = 8'h34; mem[4] = 8'hF0;
        mem[13'h1000] = 8'h5A;
        mem[13'h1234] = 8'h77;
        sb_en = 1'b0;
        fixed_wait = 6;
        rst = 1'b1;
        dbg_sel = 2'd0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        cyc = 0;
        while (1) begin
            @(negedge clk);
            #1;
            cyc++;
            if (mem_req && mem_we) break;
            if (cyc > 500) begin
                chk("sta_timeout", 32'(cyc), 32'd0);
                break;
            end
        end
        @(negedge clk);
        #1;
        chk("pre_rst_a0", {24'd0, dbg_acc}, 32'h5A);
        rst = 1'b1;
        #1;
        chk("rst_drop_req", {31'd0, mem_req}, 32'd0);
        chk("rst_drop_we", {31'd0, mem_we}, 32'd0);
        check_reset_state();
        repeat (2) @(posedge clk);
        chk("abandoned_store", {24'd0, mem[13'h1234]}, 32'h77);
        fixed_wait = 0;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("restart_req", {31'd0, mem_req}, 32'd1);
        chk("restart_pc", {19'd0, mem_addr}, 32'd0);
        cyc = 0;
        while (!halted && cyc < 500) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("restart_halted", {31'd0, halted}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
